// File: rtl/rasterizer_core_if.sv
// Bus between the GPU control FSM and rasterizer_core: start/vertex request
// in, frame-buffer write port and done status out.
interface rasterizer_core_if #(
  parameter int COORD_W = 10
);
  logic               start;
  logic [95:0]        p1;
  logic [95:0]        p2;
  logic [95:0]        p3;
  logic               done;
  logic [COORD_W-1:0] fb_x;
  logic [COORD_W-1:0] fb_y;
  logic [3:0]         data;
  logic               fb_we;

  modport master (output start, p1, p2, p3, input done, fb_x, fb_y, data, fb_we);
  modport slave  (input start, p1, p2, p3, output done, fb_x, fb_y, data, fb_we);
endinterface

// File: rtl/rasterizer_core.sv
// Flat-shaded triangle rasterizer: float vertices -> pixel coords -> bbox scan.
// Optional macro BACKFACE_CULL_EN drops triangles with positive signed area.
module rasterizer_core #(
  parameter int         SCREEN_W   = 640,
  parameter int         SCREEN_H   = 480,
  parameter int         COORD_W    = 10,
  parameter logic [3:0] FILL_COLOR = 4'hF
) (
  input logic               clk,
  input logic               areset,
  rasterizer_core_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    SETUP   = 3'd2,
    SCAN    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [23:0] LIM_X = 24'(SCREEN_W);
  localparam logic [23:0] LIM_Y = 24'(SCREEN_H);

  // Truncating float-to-int; negatives and sub-one values go to 0, large/inf/NaN clamp.
  function automatic logic [COORD_W-1:0] f2i(input logic [31:0] f, input logic [23:0] lim);
    logic [7:0]  e;
    logic [23:0] v;
    logic [23:0] top;
    logic [COORD_W-1:0] r;
    e   = f[30:23];
    top = lim - 24'd1;
    v   = 24'd0;
    if (f[31] || (e < 8'd127)) begin
      r = '0;
    end else if (e >= 8'd137) begin
      r = top[COORD_W-1:0];
    end else begin
      v = {1'b1, f[22:0]} >> (8'd150 - e);
      if (v >= lim) r = top[COORD_W-1:0];
      else          r = v[COORD_W-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [24:0] sx(input logic [COORD_W-1:0] c);
    return $signed({{(25-COORD_W){1'b0}}, c});
  endfunction

  function automatic logic signed [24:0] edge_fn(
    input logic signed [24:0] ax, input logic signed [24:0] ay,
    input logic signed [24:0] bx, input logic signed [24:0] by,
    input logic signed [24:0] px, input logic signed [24:0] py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t state_r, state_nxt_s;
  logic [2:0][31:0]        fx_r, fx_nxt_s, fy_r, fy_nxt_s;
  logic [2:0][COORD_W-1:0] vx_r, vx_nxt_s, vy_r, vy_nxt_s;
  logic [COORD_W-1:0] xmin_r, xmin_nxt_s, xmax_r, xmax_nxt_s;
  logic [COORD_W-1:0] ymin_r, ymin_nxt_s, ymax_r, ymax_nxt_s;
  logic [COORD_W-1:0] x_r, x_nxt_s, y_r, y_nxt_s;
  logic [COORD_W-1:0] fb_x_r, fb_x_nxt_s, fb_y_r, fb_y_nxt_s;
  logic [3:0]         data_r, data_nxt_s;
  logic               fb_we_r, fb_we_nxt_s, done_r, done_nxt_s;
  logic signed [24:0] area_s, e0_s, e1_s, e2_s;
  logic               covered_s, cull_s;

  always_comb begin
    area_s = edge_fn(sx(vx_r[0]), sx(vy_r[0]), sx(vx_r[1]), sx(vy_r[1]), sx(vx_r[2]), sx(vy_r[2]));
    e0_s   = edge_fn(sx(vx_r[0]), sx(vy_r[0]), sx(vx_r[1]), sx(vy_r[1]), sx(x_r), sx(y_r));
    e1_s   = edge_fn(sx(vx_r[1]), sx(vy_r[1]), sx(vx_r[2]), sx(vy_r[2]), sx(x_r), sx(y_r));
    e2_s   = edge_fn(sx(vx_r[2]), sx(vy_r[2]), sx(vx_r[0]), sx(vy_r[0]), sx(x_r), sx(y_r));
    covered_s = ((e0_s >= 25'sd0) && (e1_s >= 25'sd0) && (e2_s >= 25'sd0)) ||
                ((e0_s <= 25'sd0) && (e1_s <= 25'sd0) && (e2_s <= 25'sd0));
`ifdef BACKFACE_CULL_EN
    cull_s = (area_s >= 25'sd0);
`else
    cull_s = (area_s == 25'sd0);
`endif
  end

  // Next-state and next-output logic for the rasterizer FSM.
  always_comb begin
    state_nxt_s = state_r;
    fx_nxt_s    = fx_r;
    fy_nxt_s    = fy_r;
    vx_nxt_s    = vx_r;
    vy_nxt_s    = vy_r;
    xmin_nxt_s  = xmin_r;
    xmax_nxt_s  = xmax_r;
    ymin_nxt_s  = ymin_r;
    ymax_nxt_s  = ymax_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    fb_x_nxt_s  = fb_x_r;
    fb_y_nxt_s  = fb_y_r;
    data_nxt_s  = data_r;
    fb_we_nxt_s = 1'b0;
    done_nxt_s  = done_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          fx_nxt_s    = {bus.p3[95:64], bus.p2[95:64], bus.p1[95:64]};
          fy_nxt_s    = {bus.p3[63:32], bus.p2[63:32], bus.p1[63:32]};
          done_nxt_s  = 1'b0;
          state_nxt_s = CONVERT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONVERT: begin
        for (int i = 0; i < 3; i++) begin
          vx_nxt_s[i] = f2i(fx_r[i], LIM_X);
          vy_nxt_s[i] = f2i(fy_r[i], LIM_Y);
        end
        state_nxt_s = SETUP;
      end
      SETUP: begin
        xmin_nxt_s = min3(vx_r[0], vx_r[1], vx_r[2]);
        xmax_nxt_s = max3(vx_r[0], vx_r[1], vx_r[2]);
        ymin_nxt_s = min3(vy_r[0], vy_r[1], vy_r[2]);
        ymax_nxt_s = max3(vy_r[0], vy_r[1], vy_r[2]);
        x_nxt_s    = xmin_nxt_s;
        y_nxt_s    = ymin_nxt_s;
        if (cull_s) state_nxt_s = DONE;
        else        state_nxt_s = SCAN;
      end
      SCAN: begin
        if (covered_s) begin
          fb_we_nxt_s = 1'b1;
          fb_x_nxt_s  = x_r;
          fb_y_nxt_s  = y_r;
          data_nxt_s  = FILL_COLOR;
        end else begin
          fb_we_nxt_s = 1'b0;
        end
        if (x_r == xmax_r) begin
          x_nxt_s = xmin_r;
          if (y_r == ymax_r) state_nxt_s = DONE;
          else               y_nxt_s = y_r + 1'b1;
        end else begin
          x_nxt_s = x_r + 1'b1;
        end
      end
      DONE: begin
        done_nxt_s  = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_r <= IDLE;
      fx_r    <= '0;
      fy_r    <= '0;
      vx_r    <= '0;
      vy_r    <= '0;
      xmin_r  <= '0;
      xmax_r  <= '0;
      ymin_r  <= '0;
      ymax_r  <= '0;
      x_r     <= '0;
      y_r     <= '0;
      fb_x_r  <= '0;
      fb_y_r  <= '0;
      data_r  <= 4'd0;
      fb_we_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      fx_r    <= fx_nxt_s;
      fy_r    <= fy_nxt_s;
      vx_r    <= vx_nxt_s;
      vy_r    <= vy_nxt_s;
      xmin_r  <= xmin_nxt_s;
      xmax_r  <= xmax_nxt_s;
      ymin_r  <= ymin_nxt_s;
      ymax_r  <= ymax_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      fb_x_r  <= fb_x_nxt_s;
      fb_y_r  <= fb_y_nxt_s;
      data_r  <= data_nxt_s;
      fb_we_r <= fb_we_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.fb_x  = fb_x_r;
  assign bus.fb_y  = fb_y_r;
  assign bus.data  = data_r;
  assign bus.fb_we = fb_we_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_rasterizer_core.sv
// Directed bench for rasterizer_core: table of triangles with hand-computed
// write counts, latencies and pixel probes, plus reset / re-start sequences.
module tb_rasterizer_core;

  logic gpu_clk_150 = 1'b0;
  logic areset      = 1'b1;
  int   checks      = 0;
  int   failures    = 0;

  rasterizer_core_if bus ();

  rasterizer_core dut (
    .clk    (gpu_clk_150),
    .areset (areset),
    .bus    (bus)
  );

  always #5 gpu_clk_150 = ~gpu_clk_150;

  localparam logic [31:0] F0   = 32'h00000000;
  localparam logic [31:0] F1   = 32'h3f800000;
  localparam logic [31:0] F5   = 32'h40a00000;
  localparam logic [31:0] F10  = 32'h41200000;
  localparam logic [31:0] F20  = 32'h41a00000;
  localparam logic [31:0] F30  = 32'h41f00000;
  localparam logic [31:0] F69  = 32'h428a0000;
  localparam logic [31:0] F169 = 32'h43290000;
  localparam logic [31:0] F630 = 32'h441d8000;
  localparam logic [31:0] F700 = 32'h442f0000;
  localparam logic [31:0] FM5  = 32'hc0a00000;
  localparam logic [31:0] FMH  = 32'hbf000000;
  localparam logic [31:0] FH   = 32'h3f000000;
  localparam logic [31:0] F1H  = 32'h3fc00000;

  typedef struct {
    logic [31:0] ax, ay, bx, by, cx, cy;
    int exp_w;
    int exp_lat;
    int np;
    logic [4:0][9:0] prx;
    logic [4:0][9:0] pry;
    logic [4:0]      pe;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] ax, ay, bx, by, cx, cy,
                         input int w, input int lat);
    vecs[i].ax = ax; vecs[i].ay = ay; vecs[i].bx = bx;
    vecs[i].by = by; vecs[i].cx = cx; vecs[i].cy = cy;
    vecs[i].exp_w = w; vecs[i].exp_lat = lat; vecs[i].np = 0;
    vecs[i].prx = '0; vecs[i].pry = '0; vecs[i].pe = '0;
  endtask

  task automatic add_probe(input int i, input int x, input int y, input bit e);
    int k;
    k = vecs[i].np;
    vecs[i].prx[k] = 10'(x);
    vecs[i].pry[k] = 10'(y);
    vecs[i].pe[k]  = e;
    vecs[i].np     = k + 1;
  endtask

  task automatic run_tri(input int idx, input int repulse_at);
    int cyc, nw, lat;
    bit oob, bad_data;
    bit wr[int];
    vec_t v;
    v = vecs[idx];
    cyc = 0; nw = 0; lat = -1; oob = 1'b0; bad_data = 1'b0;
    @(negedge gpu_clk_150);
    bus.p1 = {v.ax, v.ay, 32'h0};
    bus.p2 = {v.bx, v.by, 32'h0};
    bus.p3 = {v.cx, v.cy, 32'h0};
    bus.start = 1'b1;
    @(posedge gpu_clk_150); #1;
    bus.start = 1'b0;
    bus.p1 = {F0, F0, 32'h0};
    chk($sformatf("v%0d_done_cleared", idx), int'(bus.done), 0);
    while (lat < 0 && cyc < 20000) begin
      @(posedge gpu_clk_150); #1;
      cyc++;
      if (cyc == repulse_at) begin
        bus.p1 = {F5, F5, 32'h0};
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.fb_we) begin
        nw++;
        wr[int'(bus.fb_y) * 640 + int'(bus.fb_x)] = 1'b1;
        if (bus.fb_x > 10'd639 || bus.fb_y > 10'd479) oob = 1'b1;
        if (bus.data != 4'hF) bad_data = 1'b1;
      end
      if (bus.done) lat = cyc;
    end
    bus.start = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_writes", idx), nw, v.exp_w);
    chk($sformatf("v%0d_in_bounds", idx), int'(oob), 0);
    chk($sformatf("v%0d_data_color", idx), int'(bad_data), 0);
    for (int k = 0; k < v.np; k++) begin
      chk($sformatf("v%0d_pixel_%0d_%0d", idx, v.prx[k], v.pry[k]),
          int'(wr.exists(int'(v.pry[k]) * 640 + int'(v.prx[k]))), int'(v.pe[k]));
    end
    repeat (3) @(posedge gpu_clk_150);
    #1;
    chk($sformatf("v%0d_done_held", idx), int'(bus.done), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.p1 = '0; bus.p2 = '0; bus.p3 = '0;

    set_vec(0, F69, F69, F69, F169, F169, F69, 5151, 10204);
    add_probe(0, 69, 69, 1'b1);   add_probe(0, 169, 69, 1'b1);
    add_probe(0, 69, 169, 1'b1);  add_probe(0, 119, 119, 1'b1);
    add_probe(0, 120, 120, 1'b0);
`ifdef BACKFACE_CULL_EN
    set_vec(1, F69, F69, F169, F69, F69, F169, 0, 3);
    add_probe(1, 69, 69, 1'b0);
    set_vec(5, F0, F0, F1, F0, F0, F1, 0, 3);
    add_probe(5, 0, 0, 1'b0);
    set_vec(6, FMH, FH, F1H, F0, F0, F1H, 0, 3);
    add_probe(6, 0, 0, 1'b0);
`else
    set_vec(1, F69, F69, F169, F69, F69, F169, 5151, 10204);
    add_probe(1, 119, 119, 1'b1); add_probe(1, 120, 120, 1'b0);
    set_vec(5, F0, F0, F1, F0, F0, F1, 3, 7);
    add_probe(5, 0, 0, 1'b1); add_probe(5, 1, 0, 1'b1);
    add_probe(5, 0, 1, 1'b1); add_probe(5, 1, 1, 1'b0);
    set_vec(6, FMH, FH, F1H, F0, F0, F1H, 3, 7);
    add_probe(6, 0, 0, 1'b1); add_probe(6, 1, 0, 1'b1);
    add_probe(6, 0, 1, 1'b1); add_probe(6, 1, 1, 1'b0);
`endif
    set_vec(2, F10, F10, F20, F20, F30, F30, 0, 3);
    add_probe(2, 20, 20, 1'b0);
    set_vec(3, F700, FM5, F630, F0, F700, F10, 56, 113);
    add_probe(3, 639, 0, 1'b1);  add_probe(3, 630, 0, 1'b1);
    add_probe(3, 639, 10, 1'b1); add_probe(3, 631, 9, 1'b0);
    add_probe(3, 635, 5, 1'b1);
    set_vec(4, F5, F5, F5, F5, F5, F5, 0, 3);
    add_probe(4, 5, 5, 1'b0);

    // Reset state
    repeat (3) @(posedge gpu_clk_150);
    #1;
    chk("rst_done", int'(bus.done), 0);
    chk("rst_fb_we", int'(bus.fb_we), 0);
    chk("rst_fb_x", int'(bus.fb_x), 0);
    chk("rst_fb_y", int'(bus.fb_y), 0);
    chk("rst_data", int'(bus.data), 0);
    @(negedge gpu_clk_150);
    areset = 1'b0;

    for (int i = 0; i < NV; i++) run_tri(i, 0);

    // start re-pulsed mid-scan must not disturb the running triangle
    run_tri(0, 200);

    // Reset in the middle of a scan
    @(negedge gpu_clk_150);
    bus.p1 = {F69, F69, 32'h0};
    bus.p2 = {F69, F169, 32'h0};
    bus.p3 = {F169, F69, 32'h0};
    bus.start = 1'b1;
    @(negedge gpu_clk_150);
    bus.start = 1'b0;
    repeat (50) @(negedge gpu_clk_150);
    areset = 1'b1;
    @(posedge gpu_clk_150); #1;
    chk("midrst_fb_we", int'(bus.fb_we), 0);
    chk("midrst_done", int'(bus.done), 0);
    @(negedge gpu_clk_150);
    areset = 1'b0;
    begin
      int stray;
      stray = 0;
      repeat (20) begin
        @(posedge gpu_clk_150); #1;
        if (bus.fb_we || bus.done) stray++;
      end
      chk("midrst_idle_quiet", stray, 0);
    end

    // Normal operation resumes after the abort
    run_tri(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
